// File: rtl/ms_arbiter.sv
// ms_arbiter: round-robin front end that shares one serial maze solver among
// N_REQ requesters. The owner's maze is streamed bit-serially into the solver.
// The solver's path or fail beats are then returned, tagged with the owner index.
// Optional build macro MS_ARB_WDOG_EN adds a watchdog. It aborts a silent solver
// after TIMEOUT cycles and pulses ms_clr_n low for two cycles.
module ms_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAZE_BITS = 225,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_bit,
    output logic [N_REQ-1:0]         gnt,
    output logic                     ms_in_valid,
    output logic                     ms_maze,
    output logic                     ms_clr_n,
    input  logic                     ms_out_valid,
    input  logic                     ms_not_valid,
    input  logic [3:0]               ms_x,
    input  logic [3:0]               ms_y,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [3:0]               rsp_x,
    output logic [3:0]               rsp_y,
    output logic                     rsp_fail,
    output logic                     done,
    output logic [7:0]               rsp_len
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = $clog2(MAZE_BITS + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    // Reject configurations the counters and index widths are not sized for.
    if (N_REQ < 2 || N_REQ > 8 || MAZE_BITS < 1 || GAP < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("ms_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         len_q, len_d;

    logic [N_REQ-1:0]   gnt_d;
    logic               in_valid_d;
    logic               maze_d;
    logic               rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_d;
    logic [3:0]         rsp_x_d;
    logic [3:0]         rsp_y_d;
    logic               rsp_fail_d;
    logic               done_d;
    logic [7:0]         rsp_len_d;

    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    pick;
    logic               found;

`ifdef MS_ARB_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [1:0]         clr_cnt_q, clr_cnt_d;
    logic               clr_n_d;
`endif

    // Next-state, round-robin pick and registered-output values for every state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        len_d       = len_q;
        gnt_d       = gnt;
        in_valid_d  = 1'b0;
        maze_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_x_d     = '0;
        rsp_y_d     = '0;
        rsp_fail_d  = 1'b0;
        done_d      = 1'b0;
        rsp_len_d   = '0;
`ifdef MS_ARB_WDOG_EN
        wd_cnt_d    = wd_cnt_q;
        clr_cnt_d   = (clr_cnt_q != 2'd0) ? clr_cnt_q - 2'd1 : 2'd0;
`endif

        // Scan downward so the candidate closest after 'last' is written last and wins.
        cand  = '0;
        pick  = last_q;
        found = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_q) + i) % N_REQ);
            if (req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    bit_cnt_d   = '0;
                    len_d       = '0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                in_valid_d = 1'b1;
                maze_d     = req_bit[owner_q];
`ifdef MS_ARB_WDOG_EN
                wd_cnt_d   = '0;
`endif
                if (bit_cnt_q == BIT_W'(MAZE_BITS - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = ST_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            ST_WAIT, ST_DRAIN: begin
                if (ms_out_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_x_d     = ms_x;
                    rsp_y_d     = ms_y;
                    rsp_fail_d  = ms_not_valid;
                    len_d       = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
                    state_d     = ST_DRAIN;
`ifdef MS_ARB_WDOG_EN
                    wd_cnt_d    = '0;
`endif
                end else if (state_q == ST_DRAIN) begin
                    done_d    = 1'b1;
                    rsp_len_d = len_q;
                    gnt_d     = '0;
                    last_d    = owner_q;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
`ifdef MS_ARB_WDOG_EN
                else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_fail_d  = 1'b1;
                    done_d      = 1'b1;
                    rsp_len_d   = 8'd1;
                    gnt_d       = '0;
                    last_d      = owner_q;
                    gap_cnt_d   = '0;
                    wd_cnt_d    = '0;
                    clr_cnt_d   = 2'd2;
                    state_d     = ST_GAP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end

            ST_GAP: begin
                if (int'(gap_cnt_q) + 1 >= GAP) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

`ifdef MS_ARB_WDOG_EN
        clr_n_d = (clr_cnt_d == 2'd0);
`endif
    end

    // State, bookkeeping counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            len_q       <= '0;
            gnt         <= '0;
            ms_in_valid <= 1'b0;
            ms_maze     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_fail    <= 1'b0;
            done        <= 1'b0;
            rsp_len     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            len_q       <= len_d;
            gnt         <= gnt_d;
            ms_in_valid <= in_valid_d;
            ms_maze     <= maze_d;
            rsp_valid   <= rsp_valid_d;
            rsp_id      <= rsp_id_d;
            rsp_x       <= rsp_x_d;
            rsp_y       <= rsp_y_d;
            rsp_fail    <= rsp_fail_d;
            done        <= done_d;
            rsp_len     <= rsp_len_d;
        end
    end

`ifdef MS_ARB_WDOG_EN
    // Watchdog counter and the two-cycle solver clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            clr_cnt_q <= 2'd0;
            ms_clr_n  <= 1'b1;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            clr_cnt_q <= clr_cnt_d;
            ms_clr_n  <= clr_n_d;
        end
    end
`else
    assign ms_clr_n = 1'b1;
`endif

endmodule
